cmd_decoder: RTL and testbench

- Consumes bytes from the UART receiver (115200 baud, 50 MHz clk) and turns single-byte flight commands into PID setpoints: throttle, pitch, roll and yaw-rate.
- Owns arm/disarm sequencing, slew-limited throttle ramps, and a link-loss failsafe.
- Sits between uart_rx and the attitude PID stage inside drone_top.

---
 rtl/drone_pkg.sv | 25 ++
 rtl/slew_ramp.sv | 67 ++++++
 rtl/cmd_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_cmd_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/drone_pkg.sv
// Shared types for the flight command path:
// command byte codes, decoder states, setpoint width.
package drone_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_FLY    = 2'd2,
    ST_LAND   = 2'd3
  } state_e;

  localparam logic [7:0] CMD_STOP    = 8'h00;
  localparam logic [7:0] CMD_TAKEOFF = 8'h01;
  localparam logic [7:0] CMD_LAND    = 8'h02;
  localparam logic [7:0] CMD_FWD     = 8'h03;
  localparam logic [7:0] CMD_BACK    = 8'h04;
  localparam logic [7:0] CMD_LEFT    = 8'h05;
  localparam logic [7:0] CMD_RIGHT   = 8'h06;
  localparam logic [7:0] CMD_HOVER   = 8'h07;
  localparam logic [7:0] CMD_YAW_L   = 8'h08;
  localparam logic [7:0] CMD_YAW_R   = 8'h09;

endpackage

// File: rtl/slew_ramp.sv
// Slew-limited value: steps 1 LSB toward its target
// once every DIV cycles while running.
module slew_ramp #(
  parameter int W   = 16,
  parameter int DIV = 50000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  input  logic         i_clr,
  input  logic         i_set,
  input  logic [W-1:0] i_tgt,
  output logic [W-1:0] o_val,
  output logic         o_done,
  output logic         o_chg
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_n;
  logic [W-1:0]  r_val;
  logic [W-1:0]  r_tgt;
  logic [W-1:0]  w_val_n;
  logic [W-1:0]  w_tgt_n;
  logic          w_wrap;
  logic          w_new_tgt;

  always_comb begin
    w_wrap    = i_run && (r_div == DW'(DIV - 1));
    w_new_tgt = i_set && (i_tgt != r_tgt);
    w_div_n   = '0;
    if (i_run && !w_wrap && !i_clr)
      w_div_n = r_div + 1'b1;
    w_val_n = r_val;
    w_tgt_n = r_tgt;
    // a fresh target swallows the step due this cycle
    if (i_clr) begin
      w_val_n = '0;
      w_tgt_n = '0;
    end else if (w_new_tgt) begin
      w_tgt_n = i_tgt;
    end else if (w_wrap) begin
      if (r_val < r_tgt)
        w_val_n = r_val + 1'b1;
      else if (r_val > r_tgt)
        w_val_n = r_val - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_val <= '0;
      r_tgt <= '0;
    end else begin
      r_div <= w_div_n;
      r_val <= w_val_n;
      r_tgt <= w_tgt_n;
    end
  end

  assign o_val  = r_val;
  assign o_done = (r_val == r_tgt);
  assign o_chg  = (w_val_n != r_val);

endmodule

// File: rtl/cmd_decoder.sv
// Byte command decoder: arm/disarm sequencing, throttle
// ramp, attitude setpoints and link-loss failsafe.
module cmd_decoder
  import drone_pkg::*;
#(
  parameter int W           = drone_pkg::W,
  parameter int THR_HOVER   = 600,
  parameter int ANGLE_STEP  = 100,
  parameter int YAW_STEP    = 200,
  parameter int RAMP_DIV    = 50000,
  parameter int TIMEOUT_CYC = 25000000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_armed,
  output logic [W-1:0] o_thr_sp,
  output logic [W-1:0] o_pitch_sp,
  output logic [W-1:0] o_roll_sp,
  output logic [W-1:0] o_yaw_sp,
  output logic         o_sp_valid,
  output logic         o_cmd_err,
  output logic         o_failsafe,
  output logic [1:0]   o_fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] HOVER = W'(THR_HOVER);
  localparam logic [W-1:0] ANG   = W'(ANGLE_STEP);
  localparam logic [W-1:0] YAW   = W'(YAW_STEP);

  state_e        r_state;
  state_e        w_state_n;
  logic          r_armed;
  logic          w_armed_n;
  logic [W-1:0]  r_pitch;
  logic [W-1:0]  r_roll;
  logic [W-1:0]  r_yaw;
  logic [W-1:0]  w_pitch_n;
  logic [W-1:0]  w_roll_n;
  logic [W-1:0]  w_yaw_n;
  logic          r_fs;
  logic          w_fs_n;
  logic          r_err;
  logic          w_err_n;
  logic          r_spv;
  logic          w_spv_n;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_n;

  logic          w_fly;
  logic          w_cnt_en;
  logic          w_expire;
  logic          w_run;
  logic          w_clr;
  logic          w_set;
  logic [W-1:0]  w_tgt;
  logic [W-1:0]  w_thr;
  logic          w_done;
  logic          w_thr_chg;

  slew_ramp #(
    .W   (W),
    .DIV (RAMP_DIV)
  ) u_thr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (w_run),
    .i_clr  (w_clr),
    .i_set  (w_set),
    .i_tgt  (w_tgt),
    .o_val  (w_thr),
    .o_done (w_done),
    .o_chg  (w_thr_chg)
  );

  always_comb begin
    w_fly     = (r_state == ST_FLY);
    w_cnt_en  = (r_state == ST_SPINUP) || w_fly;
    w_run     = (r_state == ST_SPINUP) || (r_state == ST_LAND);
    w_expire  = w_cnt_en && !i_rx_valid &&
                (r_tmo == TW'(TIMEOUT_CYC - 1));
    w_state_n = r_state;
    w_armed_n = r_armed;
    w_pitch_n = r_pitch;
    w_roll_n  = r_roll;
    w_yaw_n   = r_yaw;
    w_fs_n    = r_fs;
    w_err_n   = 1'b0;
    w_clr     = 1'b0;
    w_set     = 1'b0;
    w_tgt     = '0;
    w_tmo_n   = w_cnt_en ? r_tmo + 1'b1 : '0;

    if (r_state == ST_SPINUP && w_done)
      w_state_n = ST_FLY;
    if (r_state == ST_LAND && w_done) begin
      w_state_n = ST_IDLE;
      w_armed_n = 1'b0;
    end

    if (w_expire) begin
      w_tmo_n   = '0;
      w_state_n = ST_LAND;
      w_fs_n    = 1'b1;
      w_pitch_n = '0;
      w_roll_n  = '0;
      w_yaw_n   = '0;
      w_set     = 1'b1;
    end

    // a received byte overrides ramp completion and expiry
    if (i_rx_valid) begin
      w_tmo_n = '0;
      unique case (i_rx_data)
        CMD_STOP: begin
          w_state_n = ST_IDLE;
          w_armed_n = 1'b0;
          w_pitch_n = '0;
          w_roll_n  = '0;
          w_yaw_n   = '0;
          w_fs_n    = 1'b0;
          w_clr     = 1'b1;
        end
        CMD_TAKEOFF: begin
          if (r_state == ST_IDLE ||
              r_state == ST_LAND) begin
            w_state_n = ST_SPINUP;
            w_armed_n = 1'b1;
            w_pitch_n = '0;
            w_roll_n  = '0;
            w_yaw_n   = '0;
            w_fs_n    = 1'b0;
            w_set     = 1'b1;
            w_tgt     = HOVER;
          end
        end
        CMD_LAND: begin
          if (w_cnt_en) begin
            w_state_n = ST_LAND;
            w_pitch_n = '0;
            w_roll_n  = '0;
            w_yaw_n   = '0;
            w_set     = 1'b1;
          end
        end
        CMD_FWD, CMD_BACK: begin
          if (w_fly) begin
            w_pitch_n = (i_rx_data == CMD_FWD) ? -ANG : ANG;
            w_roll_n  = '0;
            w_yaw_n   = '0;
          end
        end
        CMD_LEFT, CMD_RIGHT: begin
          if (w_fly) begin
            w_roll_n  = (i_rx_data == CMD_LEFT) ? -ANG : ANG;
            w_pitch_n = '0;
            w_yaw_n   = '0;
          end
        end
        CMD_HOVER: begin
          if (w_fly) begin
            w_pitch_n = '0;
            w_roll_n  = '0;
            w_yaw_n   = '0;
          end
        end
        CMD_YAW_L, CMD_YAW_R: begin
          if (w_fly)
            w_yaw_n = (i_rx_data == CMD_YAW_L) ? -YAW : YAW;
        end
        default: w_err_n = 1'b1;
      endcase
    end

    w_spv_n = w_thr_chg ||
              (w_pitch_n != r_pitch) ||
              (w_roll_n  != r_roll)  ||
              (w_yaw_n   != r_yaw);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_pitch <= '0;
      r_roll  <= '0;
      r_yaw   <= '0;
      r_fs    <= 1'b0;
      r_err   <= 1'b0;
      r_spv   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_n;
      r_armed <= w_armed_n;
      r_pitch <= w_pitch_n;
      r_roll  <= w_roll_n;
      r_yaw   <= w_yaw_n;
      r_fs    <= w_fs_n;
      r_err   <= w_err_n;
      r_spv   <= w_spv_n;
      r_tmo   <= w_tmo_n;
    end
  end

  assign o_armed     = r_armed;
  assign o_thr_sp    = w_thr;
  assign o_pitch_sp  = r_pitch;
  assign o_roll_sp   = r_roll;
  assign o_yaw_sp    = r_yaw;
  assign o_sp_valid  = r_spv;
  assign o_cmd_err   = r_err;
  assign o_failsafe  = r_fs;
  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder with a queue of
// expected output snapshots.
module tb_cmd_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        armed;
  logic [15:0] thr;
  logic [15:0] pitch;
  logic [15:0] roll;
  logic [15:0] yaw;
  logic        spv;
  logic        err;
  logic        fs;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] P100 = 16'd100;
  localparam logic [15:0] N100 = 16'hFF9C;
  localparam logic [15:0] N200 = 16'hFF38;

  typedef struct packed {
    logic        armed;
    logic [15:0] thr;
    logic [15:0] pitch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic        spv;
    logic        err;
    logic        fs;
    logic [1:0]  st;
  } exp_t;

  exp_t  q[$];
  string tq[$];

  cmd_decoder #(
    .W           (16),
    .THR_HOVER   (8),
    .ANGLE_STEP  (100),
    .YAW_STEP    (200),
    .RAMP_DIV    (4),
    .TIMEOUT_CYC (200)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_armed     (armed),
    .o_thr_sp    (thr),
    .o_pitch_sp  (pitch),
    .o_roll_sp   (roll),
    .o_yaw_sp    (yaw),
    .o_sp_valid  (spv),
    .o_cmd_err   (err),
    .o_failsafe  (fs),
    .o_fsm_state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag,
                      input logic a,
                      input logic [15:0] t,
                      input logic [15:0] p,
                      input logic [15:0] r,
                      input logic [15:0] y,
                      input logic v,
                      input logic e,
                      input logic f,
                      input logic [1:0] s);
    exp_t x;
    x.armed = a; x.thr = t; x.pitch = p;
    x.roll = r; x.yaw = y; x.spv = v;
    x.err = e; x.fs = f; x.st = s;
    q.push_back(x);
    tq.push_back(tag);
  endtask

  task automatic cmp(input string tag,
                     input string fld,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, fld, obs, exp);
    end
  endtask

  task automatic chk();
    exp_t  x;
    string tag;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    x   = q.pop_front();
    tag = tq.pop_front();
    cmp(tag, "armed", 16'(armed), 16'(x.armed));
    cmp(tag, "thr",   thr,        x.thr);
    cmp(tag, "pitch", pitch,      x.pitch);
    cmp(tag, "roll",  roll,       x.roll);
    cmp(tag, "yaw",   yaw,        x.yaw);
    cmp(tag, "spv",   16'(spv),   16'(x.spv));
    cmp(tag, "err",   16'(err),   16'(x.err));
    cmp(tag, "fs",    16'(fs),    16'(x.fs));
    cmp(tag, "st",    16'(st),    16'(x.st));
  endtask

  // all tasks start and end just after a falling edge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk();
    rst = 1'b0;
    push("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk();

    push("takeoff", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("ramp1", 1, 1, 0, 0, 0, 1, 0, 0, 1);
    idle(4); chk();
    push("ramp1b", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1); chk();
    push("ramp8", 1, 8, 0, 0, 0, 1, 0, 0, 1);
    idle(27); chk();
    push("fly", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(1); chk();

    push("fwd", 1, 8, N100, 0, 0, 1, 0, 0, 2);
    send(8'h03); chk();
    push("right", 1, 8, 0, P100, 0, 1, 0, 0, 2);
    send(8'h06); chk();
    push("yawl", 1, 8, 0, P100, N200, 1, 0, 0, 2);
    send(8'h08); chk();
    push("yawl2", 1, 8, 0, P100, N200, 0, 0, 0, 2);
    send(8'h08); chk();
    push("bad_fly", 1, 8, 0, P100, N200, 0, 1, 0, 2);
    send(8'h7F); chk();
    push("err_off", 1, 8, 0, P100, N200, 0, 0, 0, 2);
    idle(1); chk();

    push("pre_tmo", 1, 8, 0, P100, N200, 0, 0, 0, 2);
    idle(198); chk();
    push("timeout", 1, 8, 0, 0, 0, 1, 0, 1, 3);
    idle(1); chk();
    push("land7", 1, 7, 0, 0, 0, 1, 0, 1, 3);
    idle(4); chk();
    push("land0", 1, 0, 0, 0, 0, 1, 0, 1, 3);
    idle(28); chk();
    push("disarm", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1); chk();

    push("left_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    send(8'h05); chk();
    push("bad_idle", 0, 0, 0, 0, 0, 0, 1, 1, 0);
    send(8'h7F); chk();
    push("takeoff2", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("thr4", 1, 4, 0, 0, 0, 1, 0, 0, 1);
    idle(16); chk();
    push("stop", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    send(8'h00); chk();

    push("takeoff3", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("fly3", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(33); chk();
    push("back", 1, 8, P100, 0, 0, 1, 0, 0, 2);
    send(8'h04); chk();
    rst = 1'b1;
    push("rst_fly", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1); chk();
    rst = 1'b0;

    push("takeoff4", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("fly4", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(33); chk();
    push("fwd4", 1, 8, N100, 0, 0, 1, 0, 0, 2);
    send(8'h03); chk();
    push("edge_pre", 1, 8, N100, 0, 0, 0, 0, 0, 2);
    idle(199); chk();
    push("edge_hover", 1, 8, 0, 0, 0, 1, 0, 0, 2);
    send(8'h07); chk();
    push("reload", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(199); chk();
    push("timeout2", 1, 8, 0, 0, 0, 0, 0, 1, 3);
    idle(1); chk();

    push("relaunch", 1, 8, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("fly5", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(1); chk();
    push("land_cmd", 1, 8, 0, 0, 0, 0, 0, 0, 3);
    send(8'h02); chk();
    push("land_pre", 1, 8, 0, 0, 0, 0, 0, 0, 3);
    idle(3); chk();
    push("drop_step", 1, 8, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01); chk();
    push("fly6", 1, 8, 0, 0, 0, 0, 0, 0, 2);
    idle(1); chk();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
